// File: rtl/mac_seq_ctrl_pkg.sv
// mac_seq_ctrl_pkg: shared widths, mode codes, state encodings and conf-field
// positions for the MAC job sequencer.
package mac_seq_ctrl_pkg;
    localparam int MAC_MIN_WIDTH  = 8;
    localparam int MAC_ACC_WIDTH  = 32;
    localparam int MAC_CONF_WIDTH = 4;
    localparam int MAC_SEQ_LEN_W  = 8;

    localparam logic [1:0] MAC_SINGLE  = 2'd0;
    localparam logic [1:0] MAC_DUAL    = 2'd1;
    localparam logic [1:0] MAC_QUAD    = 2'd2;
    localparam logic [1:0] MAC_ILLEGAL = 2'd3;

    localparam logic [2:0] MAC_SEQ_IDLE  = 3'd0;
    localparam logic [2:0] MAC_SEQ_LOAD  = 3'd1;
    localparam logic [2:0] MAC_SEQ_RUN   = 3'd2;
    localparam logic [2:0] MAC_SEQ_DRAIN = 3'd3;
    localparam logic [2:0] MAC_SEQ_ERR   = 3'd4;
    localparam logic [2:0] MAC_SEQ_DONE  = 3'd5;

    // Mode occupies conf[1:0]; the accumulate flag sits in the conf MSB.
    localparam int MAC_CONF_MODE_LSB = 0;
endpackage

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: job-level sequencer that loads the MAC, streams operand beats
// and returns the captured result over a valid/ready port.
module mac_seq_ctrl
    import mac_seq_ctrl_pkg::*;
#(
    parameter int MIN_W  = MAC_MIN_WIDTH,
    parameter int ACC_W  = MAC_ACC_WIDTH,
    parameter int CONF_W = MAC_CONF_WIDTH,
    parameter int LEN_W  = MAC_SEQ_LEN_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    job_valid,
    output logic                    job_ready,
    input  logic [1:0]              job_mode,
    input  logic                    job_acc,
    input  logic [ACC_W-1:0]        job_init,
    input  logic [LEN_W-1:0]        job_len,
    input  logic                    op_valid,
    output logic                    op_ready,
    input  logic [MIN_W-1:0]        op_a0,
    input  logic [MIN_W-1:0]        op_a1,
    input  logic [MIN_W-1:0]        op_a2,
    input  logic [MIN_W-1:0]        op_a3,
    input  logic [MIN_W-1:0]        op_b1,
    output logic                    mac_rst,
    output logic                    mac_en,
    output logic [ACC_W+CONF_W-1:0] mac_cfg,
    output logic [MIN_W-1:0]        mac_a0,
    output logic [MIN_W-1:0]        mac_a1,
    output logic [MIN_W-1:0]        mac_a2,
    output logic [MIN_W-1:0]        mac_a3,
    output logic [MIN_W-1:0]        mac_b1,
    input  logic [ACC_W-1:0]        mac_c,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [ACC_W-1:0]        res_data,
    output logic                    res_err,
    output logic                    busy
);
    logic [2:0]        state, next;
    logic [LEN_W-1:0]  cnt;
    logic [CONF_W-1:0] conf;
    logic              fire;

    assign job_ready = state == MAC_SEQ_IDLE;
    assign op_ready  = state == MAC_SEQ_RUN;
    assign fire      = op_ready && op_valid;
    assign mac_en    = fire;
    assign mac_a0    = fire ? op_a0 : '0;
    assign mac_a1    = fire ? op_a1 : '0;
    assign mac_a2    = fire ? op_a2 : '0;
    assign mac_a3    = fire ? op_a3 : '0;
    assign mac_b1    = fire ? op_b1 : '0;

    always_comb begin
        conf = '0;
        conf[CONF_W-1] = job_acc;
        conf[MAC_CONF_MODE_LSB +: 2] = job_mode;
    end

    always_comb begin
        next = state;
        case (state)
            MAC_SEQ_IDLE:  next = job_valid ? (job_mode == MAC_ILLEGAL ? MAC_SEQ_ERR : MAC_SEQ_LOAD) : state;
            MAC_SEQ_LOAD:  next = MAC_SEQ_RUN;
            MAC_SEQ_RUN:   next = (fire && cnt == '0) ? MAC_SEQ_DRAIN : state;
            MAC_SEQ_DRAIN: next = MAC_SEQ_DONE;
            MAC_SEQ_ERR:   next = MAC_SEQ_DONE;
            MAC_SEQ_DONE:  next = res_ready ? MAC_SEQ_IDLE : state;
            default:       next = MAC_SEQ_IDLE;
        endcase
    end

    // mac_rst resets high so the MAC is held in reset while rst is asserted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= MAC_SEQ_IDLE;
            cnt       <= '0;
            mac_cfg   <= '0;
            mac_rst   <= 1'b1;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= next;
            mac_rst   <= next == MAC_SEQ_LOAD;
            res_valid <= next == MAC_SEQ_DONE;
            busy      <= next != MAC_SEQ_IDLE;
            if (job_ready && job_valid) begin
                cnt     <= job_acc ? job_len : '0;
                mac_cfg <= {job_init, conf};
            end
            if (fire && cnt != '0) cnt <= cnt - LEN_W'(1);
            if (state == MAC_SEQ_DRAIN) begin
                res_data <= mac_c;
                res_err  <= 1'b0;
            end
            if (state == MAC_SEQ_ERR) begin
                res_data <= '0;
                res_err  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: directed and randomized jobs against a job-level reference
// model, with a small behavioural MAC closing the loop on mac_c.
module tb_mac_seq_ctrl;
    localparam int MW = 8, AW = 32, CW = 4, LW = 8;

    logic          clk = 1'b0, rst = 1'b0;
    logic          job_valid = 1'b0, job_ready, job_acc = 1'b0;
    logic [1:0]    job_mode = 2'd0;
    logic [AW-1:0] job_init = '0;
    logic [LW-1:0] job_len = '0;
    logic          op_valid = 1'b0, op_ready;
    logic [MW-1:0] op_a0 = '0, op_a1 = '0, op_a2 = '0, op_a3 = '0, op_b1 = '0;
    logic          mac_rst, mac_en;
    logic [AW+CW-1:0] mac_cfg;
    logic [MW-1:0] mac_a0, mac_a1, mac_a2, mac_a3, mac_b1;
    logic [AW-1:0] mac_c;
    logic          res_valid, res_ready = 1'b0, res_err, busy;
    logic [AW-1:0] res_data;

    int checks = 0, errors = 0, en_cnt = 0, rst_cnt = 0, e0 = 0, r0 = 0;
    logic [MW-1:0] av [0:255][0:3];
    logic [MW-1:0] bv [0:255];

    mac_seq_ctrl dut (
        .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
        .job_mode(job_mode), .job_acc(job_acc), .job_init(job_init), .job_len(job_len),
        .op_valid(op_valid), .op_ready(op_ready), .op_a0(op_a0), .op_a1(op_a1),
        .op_a2(op_a2), .op_a3(op_a3), .op_b1(op_b1), .mac_rst(mac_rst), .mac_en(mac_en),
        .mac_cfg(mac_cfg), .mac_a0(mac_a0), .mac_a1(mac_a1), .mac_a2(mac_a2),
        .mac_a3(mac_a3), .mac_b1(mac_b1), .mac_c(mac_c), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .res_err(res_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural MAC: one result register, loaded on mac_rst, updated on mac_en.
    function automatic logic [AW-1:0] lanes(input logic [1:0] m, input logic [MW-1:0] a0, a1, a2, a3, b);
        logic [AW-1:0] p0, p1, p2, p3;
        p0 = AW'(a0) * AW'(b);
        p1 = AW'(a1) * AW'(b);
        p2 = AW'(a2) * AW'(b);
        p3 = AW'(a3) * AW'(b);
        return m == 2'd0 ? p1 : m == 2'd1 ? p0 + (p1 << 8) : p0 + (p1 << 8) + (p2 << 16) + (p3 << 24);
    endfunction

    always @(posedge clk) begin
        if (mac_rst) mac_c <= mac_cfg[AW+CW-1:CW];
        else if (mac_en) mac_c <= (mac_cfg[CW-1] ? mac_c : '0) + lanes(mac_cfg[1:0], mac_a0, mac_a1, mac_a2, mac_a3, mac_b1);
        if (mac_en) en_cnt++;
        if (mac_rst) rst_cnt++;
    end

    // Job-level reference: init plus the sum of active-lane products over all beats.
    function automatic logic [AW-1:0] ref_result(input logic [1:0] m, input logic a, input logic [AW-1:0] init, input int nb);
        logic [AW-1:0] r;
        if (m == 2'd3) return '0;
        r = a ? init : '0;
        for (int k = 0; k < nb; k++)
            for (int i = 0; i < 4; i++)
                if (m == 2'd2 || (m == 2'd1 && i < 2) || (m == 2'd0 && i == 1))
                    r += (AW'(av[k][i]) * AW'(bv[k])) << (m == 2'd0 ? 0 : 8 * i);
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic fill_rand;
        for (int k = 0; k < 256; k++) begin
            for (int i = 0; i < 4; i++) av[k][i] = MW'($urandom);
            bv[k] = MW'($urandom);
        end
    endtask

    task automatic start_job(input logic [1:0] m, input logic a, input logic [AW-1:0] init, input logic [LW-1:0] len);
        check("job_ready_idle", job_ready, 1);
        job_valid = 1; job_mode = m; job_acc = a; job_init = init; job_len = len;
        e0 = en_cnt; r0 = rst_cnt;
        tick;
        job_valid = 0;
        check("busy_after_accept", busy, 1);
        check("job_ready_busy", job_ready, 0);
        check("mac_rst_load", mac_rst, m != 2'd3);
        check("mac_cfg", mac_cfg, {init, a, 1'b0, m});
    endtask

    task automatic beat(input int k, input int gap);
        repeat (gap) begin
            tick;
            check("stall_op_ready", op_ready, 1);
            check("stall_mac_en", mac_en, 0);
        end
        op_valid = 1; op_a0 = av[k][0]; op_a1 = av[k][1]; op_a2 = av[k][2]; op_a3 = av[k][3]; op_b1 = bv[k];
        #1;
        check("beat_mac_en", mac_en, 1);
        check("beat_mac_a1", mac_a1, av[k][1]);
        tick;
        op_valid = 0; op_a0 = MW'($urandom); op_a1 = MW'($urandom); op_b1 = MW'($urandom);
    endtask

    // Runs a job up to DONE and holds res_ready low for 'hold' cycles.
    task automatic run_job(input logic [1:0] m, input logic a, input logic [AW-1:0] init, input logic [LW-1:0] len, input int gap, input int hold);
        int nb;
        logic [AW-1:0] exp;
        nb = m == 2'd3 ? 0 : (a ? int'(len) + 1 : 1);
        exp = ref_result(m, a, init, nb);
        start_job(m, a, init, len);
        tick;
        if (m != 2'd3) begin
            check("op_ready_run", op_ready, 1);
            for (int k = 0; k < nb; k++) beat(k, gap);
            check("op_ready_drain", op_ready, 0);
            check("res_valid_drain", res_valid, 0);
            tick;
        end
        check("res_valid_done", res_valid, 1);
        check("res_data", res_data, exp);
        check("res_err", res_err, m == 2'd3);
        check("beat_count", en_cnt - e0, nb);
        check("mac_rst_pulses", rst_cnt - r0, m != 2'd3);
        repeat (hold) begin
            tick;
            check("hold_valid", res_valid, 1);
            check("hold_data", res_data, exp);
            check("hold_job_ready", job_ready, 0);
        end
    endtask

    task automatic release_res;
        res_ready = 1;
        check("job_ready_done", job_ready, 0);
        tick;
        res_ready = 0;
        check("res_valid_cleared", res_valid, 0);
        check("busy_idle", busy, 0);
        check("job_ready_back", job_ready, 1);
    endtask

    initial begin
        fill_rand;
        repeat (2) tick;
        check("rst_busy", busy, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_err", res_err, 0);
        check("rst_mac_rst", mac_rst, 1);
        check("rst_op_ready", op_ready, 0);
        check("rst_mac_en", mac_en, 0);
        #3 rst = 1;
        tick;
        check("mac_rst_released", mac_rst, 0);

        av[0][1] = 2; bv[0] = 3; av[1][1] = 4; bv[1] = 5; av[2][1] = 1; bv[2] = 1;
        run_job(2'd0, 1'b1, '0, 8'd2, 0, 0);
        check("single_27", res_data, 27);
        release_res;

        fill_rand;
        av[0][0] = 3; av[0][1] = 1; bv[0] = 2;
        run_job(2'd1, 1'b0, AW'($urandom), 8'd5, 0, 0);
        check("dual_518", res_data, 518);
        release_res;

        for (int i = 0; i < 4; i++) av[0][i] = 1;
        bv[0] = 1;
        run_job(2'd2, 1'b1, 32'd100, 8'd0, 0, 0);
        check("quad_sum", res_data, 32'd100 + 32'h0101_0101);
        release_res;

        run_job(2'd3, 1'b1, AW'($urandom), 8'd7, 0, 0);
        release_res;

        fill_rand;
        run_job(2'd0, 1'b1, AW'($urandom), 8'd3, 3, 5);
        res_ready = 1; job_valid = 1; job_mode = 2'd3; job_acc = 0;
        check("simul_job_ready", job_ready, 0);
        tick;
        res_ready = 0;
        check("simul_idle_ready", job_ready, 1);
        check("simul_idle_busy", busy, 0);
        tick;
        job_valid = 0;
        check("simul_accepted", busy, 1);
        check("simul_no_mac_rst", mac_rst, 0);
        tick;
        check("simul_err_valid", res_valid, 1);
        check("simul_err_flag", res_err, 1);
        release_res;

        fill_rand;
        start_job(2'd0, 1'b1, AW'($urandom), 8'd3);
        tick;
        beat(0, 0);
        beat(1, 1);
        #2 rst = 0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_res_valid", res_valid, 0);
        check("midrst_op_ready", op_ready, 0);
        check("midrst_mac_rst", mac_rst, 1);
        tick;
        #3 rst = 1;
        tick;
        fill_rand;
        run_job(2'd0, 1'b1, AW'($urandom), 8'd3, 0, 0);
        release_res;

        for (int j = 0; j < 6; j++) begin
            fill_rand;
            run_job(2'($urandom_range(0, 3)), 1'($urandom), AW'($urandom), LW'($urandom_range(0, 15)),
                    $urandom_range(0, 2), $urandom_range(0, 2));
            release_res;
        end

        fill_rand;
        run_job(2'($urandom_range(0, 2)), 1'b1, AW'($urandom), 8'd255, 0, 1);
        release_res;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
